// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants for the regfile write-port arbiter: register file geometry
// and the hard-wired zero register index.
package wb_port_arbiter_pkg;

    localparam int AW = 5;
    localparam int DW = 32;

    localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_fifo.sv
// Load-result FIFO with per-slot valid bits and exposed storage so the arbiter
// can build the pending-register mask without walking the pointers.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int EW    = 37
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [EW-1:0]                 push_data,
    input  logic                          pop,
    output logic [EW-1:0]                 pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic [DEPTH-1:0][EW-1:0]      entries,
    output logic [DEPTH-1:0]              slot_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = entries[rptr];

    // With a power-of-two depth the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            entries    <= '0;
            slot_valid <= '0;
        end else begin
            if (do_push) begin
                entries[wptr]    <= push_data;
                slot_valid[wptr] <= 1'b1;
                wptr             <= wptr + PW'(1);
            end
            if (do_pop) begin
                slot_valid[rptr] <= 1'b0;
                rptr             <= rptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Drives the single regfile write port from the ALU path and a queued load path,
// with load anti-starvation when the queue fills and a pending-register mask.
module wb_port_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = wb_port_arbiter_pkg::AW,
    parameter int DW    = wb_port_arbiter_pkg::DW
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [AW-1:0]                 alu_wr,
    input  logic [DW-1:0]                 alu_wd,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [AW-1:0]                 mem_wr,
    input  logic [DW-1:0]                 mem_wd,
    output logic                          rf_write,
    output logic [AW-1:0]                 rf_wr,
    output logic [DW-1:0]                 rf_wd,
    output logic [2**AW-1:0]              pend_mask,
    output logic [$clog2(DEPTH+1)-1:0]    fifo_count
);

    import wb_port_arbiter_pkg::*;

    localparam int EW = AW + DW;

    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     alu_take;
    logic                     head_take;
    logic [EW-1:0]            head;
    logic [DEPTH-1:0][EW-1:0] entries;
    logic [DEPTH-1:0]         slot_valid;

    wb_fifo #(.DEPTH(DEPTH), .EW(EW)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  ({mem_wr, mem_wd}),
        .pop        (head_take),
        .pop_data   (head),
        .full       (full),
        .empty      (empty),
        .count      (fifo_count),
        .entries    (entries),
        .slot_valid (slot_valid)
    );

    // Handshake: a transfer happens on valid && ready; ready depends only on state.
    assign alu_ready = !full;
    assign mem_ready = !full;

    // Writes to $0 complete the handshake but are dropped, so a dropped ALU op
    // leaves the port free for the FIFO head.
    always_comb begin
        alu_take  = alu_valid && !full && (alu_wr != AW'(REG_ZERO));
        head_take = !empty && (full || !alu_take);
        push      = mem_valid && !full && (mem_wr != AW'(REG_ZERO));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_write <= 1'b0;
            rf_wr    <= '0;
            rf_wd    <= '0;
        end else begin
            rf_write <= alu_take || head_take;
            if (alu_take) begin
                rf_wr <= alu_wr;
                rf_wd <= alu_wd;
            end else if (head_take) begin
                rf_wr <= head[EW-1:DW];
                rf_wd <= head[DW-1:0];
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i]) pend_mask[entries[i][EW-1:DW]] = 1'b1;
        end
        if (rf_write) pend_mask[rf_wr] = 1'b1;
        pend_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a queue-based reference model predicts
// each regfile write, which the monitor compares as rf_write pulses appear.
module tb_wb_port_arbiter;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH+1);

    logic              clk;
    logic              reset;
    logic              alu_valid;
    logic              alu_ready;
    logic [AW-1:0]     alu_wr;
    logic [DW-1:0]     alu_wd;
    logic              mem_valid;
    logic              mem_ready;
    logic [AW-1:0]     mem_wr;
    logic [DW-1:0]     mem_wd;
    logic              rf_write;
    logic [AW-1:0]     rf_wr;
    logic [DW-1:0]     rf_wd;
    logic [2**AW-1:0]  pend_mask;
    logic [CW-1:0]     fifo_count;

    wb_port_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_wr     (alu_wr),
        .alu_wd     (alu_wd),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_wr     (mem_wr),
        .mem_wd     (mem_wd),
        .rf_write   (rf_write),
        .rf_wr      (rf_wr),
        .rf_wd      (rf_wd),
        .pend_mask  (pend_mask),
        .fifo_count (fifo_count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and reference model
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mq[$];
    logic             m_out_valid;
    logic [AW-1:0]    m_out_wr;
    int               n_checks;
    int               n_fail;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2**AW-1:0] model_pend();
        logic [2**AW-1:0] p;
        p = '0;
        foreach (mq[i]) p[mq[i][AW+DW-1:DW]] = 1'b1;
        if (m_out_valid) p[m_out_wr] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic model_clear();
        mq.delete();
        exp_q.delete();
        m_out_valid = 1'b0;
        m_out_wr    = '0;
    endtask

    // Driver: apply one cycle of stimulus, predict, clock, then monitor outputs.
    task automatic drive_cycle(input logic av, input logic [AW-1:0] aw, input logic [DW-1:0] ad,
                               input logic mv, input logic [AW-1:0] mw, input logic [DW-1:0] md);
        logic m_full;
        logic alu_win;
        logic head_win;
        logic [AW+DW-1:0] got;
        alu_valid = av; alu_wr = aw; alu_wd = ad;
        mem_valid = mv; mem_wr = mw; mem_wd = md;
        #1;
        m_full = (mq.size() == DEPTH);
        check_eq("alu_ready", 64'(alu_ready), 64'(!m_full));
        check_eq("mem_ready", 64'(mem_ready), 64'(!m_full));
        alu_win  = av && !m_full && (aw != 0);
        head_win = (mq.size() != 0) && (m_full || !alu_win);
        m_out_valid = alu_win || head_win;
        if (alu_win) begin
            exp_q.push_back({aw, ad});
            m_out_wr = aw;
        end else if (head_win) begin
            exp_q.push_back(mq[0]);
            m_out_wr = mq[0][AW+DW-1:DW];
            void'(mq.pop_front());
        end
        if (mv && !m_full && (mw != 0)) mq.push_back({mw, md});
        @(posedge clk);
        #1;
        check_eq("rf_write", 64'(rf_write), 64'(m_out_valid));
        if (rf_write) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", 64'({rf_wr, rf_wd}), 64'(0));
            end else begin
                got = {rf_wr, rf_wd};
                check_eq("rf_wr_wd", 64'(got), 64'(exp_q.pop_front()));
            end
        end
        check_eq("fifo_count", 64'(fifo_count), 64'(mq.size()));
        check_eq("pend_mask", 64'(pend_mask), 64'(model_pend()));
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_rf_write"}, 64'(rf_write), 64'(0));
        check_eq({tag, "_rf_wr"}, 64'(rf_wr), 64'(0));
        check_eq({tag, "_rf_wd"}, 64'(rf_wd), 64'(0));
        check_eq({tag, "_pend"}, 64'(pend_mask), 64'(0));
        check_eq({tag, "_count"}, 64'(fifo_count), 64'(0));
        check_eq({tag, "_alu_ready"}, 64'(alu_ready), 64'(1));
        check_eq({tag, "_mem_ready"}, 64'(mem_ready), 64'(1));
    endtask

    task automatic release_reset();
        @(negedge clk);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_clear();

        // Reset held with both producers offering writes.
        reset = 1'b0;
        alu_valid = 1'b1; alu_wr = 5'd3; alu_wd = 32'h1111_1111;
        mem_valid = 1'b1; mem_wr = 5'd4; mem_wd = 32'h2222_2222;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        release_reset();

        // ALU only.
        drive_cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0);
        idle_cycle();

        // Contention: ALU r10 wins, load r7 follows one cycle later.
        drive_cycle(1'b1, 5'd10, 32'hA0A0_A0A0, 1'b1, 5'd7, 32'h7777_7777);
        check_eq("pend_r7_queued", 64'(pend_mask[7]), 64'(1));
        idle_cycle();
        check_eq("pend_r7_on_port", 64'(pend_mask[7]), 64'(1));
        idle_cycle();
        check_eq("pend_r7_done", 64'(pend_mask[7]), 64'(0));

        // Fill the FIFO with loads r1..r4 while the ALU keeps winning.
        for (int i = 1; i <= 4; i++)
            drive_cycle(1'b1, AW'(20 + i), DW'($urandom), 1'b1, AW'(i), DW'(32'h100 * i));
        check_eq("full_count", 64'(fifo_count), 64'(4));
        for (int i = 0; i < 6; i++)
            drive_cycle(1'b1, AW'($urandom_range(1, 31)), DW'($urandom), 1'b1, 5'd9, DW'($urandom));
        repeat (4) idle_cycle();

        // Register $0 from both sides.
        drive_cycle(1'b1, 5'd0, 32'hBAD0_0000, 1'b1, 5'd0, 32'hBAD0_0001);
        check_eq("zero_count", 64'(fifo_count), 64'(0));
        idle_cycle();

        // Dropped ALU op alongside a queued load: load must still drain.
        drive_cycle(1'b0, '0, '0, 1'b1, 5'd12, 32'hC0C0_C0C0);
        drive_cycle(1'b1, 5'd0, 32'hBAD0_0002, 1'b0, '0, '0);
        idle_cycle();

        // Random traffic.
        for (int i = 0; i < 400; i++)
            drive_cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom),
                        1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 31)), DW'($urandom));
        repeat (6) idle_cycle();

        // Async reset mid-drain with three entries queued.
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b1, AW'(16 + i), DW'($urandom), 1'b1, AW'(11 + i), DW'($urandom));
        check_eq("pre_reset_count", 64'(fifo_count), 64'(3));
        #2;
        reset = 1'b0;
        #1;
        check_reset_state("mid_reset");
        model_clear();
        release_reset();
        repeat (5) idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
